pc_jump_unit: RTL and testbench
===============================

Name: pc_jump_unit

Overview:
- Parametrised successor to the fixed-width jump-target adder.
- Owns the fetch-stage PC register and computes the J/JAL pseudo-direct target.
- Also selects the JR target and handles stall/redirect.
- Contains a small return-address stack (RAS) that predicts JR $ra targets from JAL history; a later stage detects a wrong prediction and corrects it through redirect.

Parameters:
- ADDR_W, 32, PC/address width; must satisfy ADDR_W >= IMM_W+2.
- IMM_W, 26, jump immediate width.
- RAS_DEPTH, 4, RAS entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- stall, input, 1, hazard stall; hold PC and RAS.
- redirect, input, 1, later-stage correction (branch taken / RAS mispredict).
- redirect_pc, input, ADDR_W, correction target.
- jump_valid, input, 1, ID holds J or JAL.
- jump_link, input, 1, ID jump is JAL; qualified by jump_valid.
- jump_imm, input, IMM_W, instr[IMM_W-1:0].
- jr_valid, input, 1, ID holds JR.
- jr_is_ra, input, 1, JR source register is $31.
- jr_target, input, ADDR_W, forwarded register value for JR.
- pcp4_id, input, ADDR_W, PC+4 of the ID-stage instruction.
- pc, output, ADDR_W, current fetch PC (registered).
- pcp4, output, ADDR_W, pc+4 (combinational, wraps modulo 2^ADDR_W).
- ras_used, output, 1, JR this cycle took its target from the RAS (combinational).
- ras_count, output, clog2(RAS_DEPTH)+1, valid RAS entries (registered).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, ras_count=0, RAS pointer=0, entries cleared to 0.
  - ras_used=0 while in reset.
  - Reset asserted mid-operation aborts any pending push/pop immediately.
- Jump target: jtgt = {pcp4_id[ADDR_W-1:IMM_W+2], jump_imm, 2'b00}. When ADDR_W==IMM_W+2 there are no upper bits.
- Next-PC priority, evaluated each rising edge:
  1. redirect=1: pc<=redirect_pc, regardless of stall. RAS unchanged. All ID inputs ignored.
  2. stall=1: pc holds. No push/pop. ras_used forced 0.
  3. jr_valid=1:
     - If jr_is_ra and ras_count>0: pc<=RAS top, pop (pointer-1, count-1), ras_used=1.
     - Otherwise pc<=jr_target, no pop, ras_used=0.
  4. jump_valid=1: pc<=jtgt. If jump_link=1, push pcp4_id.
  5. Otherwise pc<=pc+4.
- jr_valid and jump_valid both 1 is illegal. Defined response: JR wins, no push.
- PC update latency: 1 cycle. pcp4 follows pc combinationally, 0 cycles.
- RAS is a circular buffer.
  - Push writes entry[ptr], then ptr<=ptr+1 (mod RAS_DEPTH).
  - Pop reads entry[ptr-1], then ptr<=ptr-1.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty cannot occur; the JR falls back to jr_target.
- ras_used is valid only in the same cycle as the JR. A later stage compares the popped value against the resolved $ra; on mismatch it drives redirect.
- No X on any output after reset. All arithmetic is unsigned modulo 2^ADDR_W.

Decomposition:
- Shared package holds:
  - next-PC select encoding: NPC_SEQ, NPC_JUMP, NPC_JR, NPC_RAS, NPC_REDIR, NPC_HOLD;
  - default ADDR_W, IMM_W and RESET_PC constants.
- One sub-module: ras_stack, parametrised by ADDR_W and RAS_DEPTH.
  - Inputs: push, pop, push_data.
  - Outputs: top, count.
- pc_jump_unit contains target generation, priority mux and the PC register.

Test Plan:
- Reset release, no control inputs for 3 cycles → pc sequence 0x0, 0x4, 0x8; pcp4=0xC; ras_count=0.
- jump_valid=1, jump_link=0, pcp4_id=0x4000_0010, jump_imm=0x0000100 → next pc=0x4000_0400; no push.
- JAL with pcp4_id=0x0000_0020 and jump_imm=0x40 → pc=0x100, ras_count=1. Then JR with jr_is_ra=1, jr_target=0xDEAD0000 → ras_used=1, pc=0x20, ras_count=0.
- 5 JALs with RAS_DEPTH=4 and link values A..E, then 5 JR $ra:
  - pops return E, D, C, B (ras_used=1 each);
  - 5th JR uses jr_target (ras_used=0); count stays 0.
- Stall and redirect interaction:
  - stall=1 with JAL present → pc and ras_count unchanged, ras_used=0.
  - stall=1 with redirect=1, redirect_pc=0x80 → pc=0x80.
- pc=0xFFFF_FFFC, sequential step → pc wraps to 0x0. rst_n pulsed low mid-cycle after pushes → pc=RESET_PC and ras_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_jump_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_jump_unit_pkg
//  Description : Shared constants for the fetch-stage PC / jump unit:
//                default widths, reset PC and the next-PC select encoding.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package pc_jump_unit_pkg;

    // Default geometry (MIPS-style 32-bit PC, 26-bit J-format immediate)
    localparam int unsigned DEF_ADDR_W   = 32;
    localparam int unsigned DEF_IMM_W    = 26;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    // Next-PC source select
    localparam int unsigned      NPC_W     = 3;
    localparam logic [NPC_W-1:0] NPC_SEQ   = 3'd0;  // pc + 4
    localparam logic [NPC_W-1:0] NPC_JUMP  = 3'd1;  // J/JAL pseudo-direct target
    localparam logic [NPC_W-1:0] NPC_JR    = 3'd2;  // JR forwarded register value
    localparam logic [NPC_W-1:0] NPC_RAS   = 3'd3;  // JR $ra predicted from RAS
    localparam logic [NPC_W-1:0] NPC_REDIR = 3'd4;  // later-stage correction
    localparam logic [NPC_W-1:0] NPC_HOLD  = 3'd5;  // stall

endpackage
`default_nettype wire

// File: rtl/pc_jump_unit_ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Circular return-address stack. Push writes entry[ptr] and
//                advances; pop retreats. Overflow silently overwrites the
//                oldest entry while the valid count saturates at RAS_DEPTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            push_data,
    output logic [ADDR_W-1:0]            top,
    output logic [$clog2(RAS_DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_entry [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_top_idx;

    // Top of stack is the slot just below the write pointer (wraps naturally)
    assign w_top_idx = r_ptr - c_ptr_one;
    assign top       = r_entry[w_top_idx];
    assign count     = r_count;

    // Stack storage, pointer and occupancy; pop takes precedence if both asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                r_entry[i] <= '0;
            end
            r_ptr   <= '0;
            r_count <= '0;
        end else if (pop && (r_count != '0)) begin
            r_ptr   <= r_ptr - c_ptr_one;
            r_count <= r_count - c_cnt_one;
        end else if (push) begin
            r_entry[r_ptr] <= push_data;
            r_ptr          <= r_ptr + c_ptr_one;
            if (r_count != c_depth) begin
                r_count <= r_count + c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_jump_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_jump_unit
//  Description : Fetch-stage PC register with J/JAL pseudo-direct target
//                generation, JR target select, stall/redirect handling and a
//                return-address stack predicting JR $ra from JAL history.
//                ADDR_W must be >= IMM_W + 2.
//  Revision    : 1.0 - parametrised successor to fixed-width jump adder
// ============================================================================
module pc_jump_unit
    import pc_jump_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W    = DEF_ADDR_W,
    parameter int unsigned        IMM_W     = DEF_IMM_W,
    parameter int unsigned        RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(DEF_RESET_PC)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic                        redirect,
    input  logic [ADDR_W-1:0]           redirect_pc,
    input  logic                        jump_valid,
    input  logic                        jump_link,
    input  logic [IMM_W-1:0]            jump_imm,
    input  logic                        jr_valid,
    input  logic                        jr_is_ra,
    input  logic [ADDR_W-1:0]           jr_target,
    input  logic [ADDR_W-1:0]           pcp4_id,
    output logic [ADDR_W-1:0]           pc,
    output logic [ADDR_W-1:0]           pcp4,
    output logic                        ras_used,
    output logic [$clog2(RAS_DEPTH):0]  ras_count
);

    localparam logic [ADDR_W-1:0] c_pc_inc = ADDR_W'(4);

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_jtgt;
    logic [ADDR_W-1:0]  w_next_pc;
    logic [NPC_W-1:0]   w_npc_sel;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_ras_top;
    logic [$clog2(RAS_DEPTH):0] w_ras_count;

    // Pseudo-direct target: upper PC bits of the ID instruction's PC+4
    generate
        if (ADDR_W > IMM_W + 2) begin : g_jtgt_upper
            logic w_unused_pcp4_lo;
            assign w_unused_pcp4_lo = &{1'b0, pcp4_id[IMM_W+1:0]};
            assign w_jtgt = {pcp4_id[ADDR_W-1:IMM_W+2], jump_imm, 2'b00};
        end else begin : g_jtgt_exact
            logic w_unused_pcp4;
            assign w_unused_pcp4 = &{1'b0, pcp4_id};
            assign w_jtgt = {jump_imm, 2'b00};
        end
    endgenerate

    // Next-PC priority: redirect > stall > JR (wins over J too) > J/JAL > sequential
    always_comb begin
        w_npc_sel = NPC_SEQ;
        if (redirect) begin
            w_npc_sel = NPC_REDIR;
        end else if (stall) begin
            w_npc_sel = NPC_HOLD;
        end else if (jr_valid) begin
            w_npc_sel = (jr_is_ra && (w_ras_count != '0)) ? NPC_RAS : NPC_JR;
        end else if (jump_valid) begin
            w_npc_sel = NPC_JUMP;
        end
    end

    // Next-PC data mux
    always_comb begin
        w_next_pc = r_pc + c_pc_inc;
        case (w_npc_sel)
            NPC_REDIR: w_next_pc = redirect_pc;
            NPC_HOLD:  w_next_pc = r_pc;
            NPC_RAS:   w_next_pc = w_ras_top;
            NPC_JR:    w_next_pc = jr_target;
            NPC_JUMP:  w_next_pc = w_jtgt;
            default:   w_next_pc = r_pc + c_pc_inc;
        endcase
    end

    // Reset gates the stack controls so nothing reports a pop while held in reset
    assign w_pop    = rst_n && (w_npc_sel == NPC_RAS);
    assign w_push   = rst_n && (w_npc_sel == NPC_JUMP) && jump_link;
    assign ras_used = w_pop;

    // Fetch PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (pcp4_id),
        .top       (w_ras_top),
        .count     (w_ras_count)
    );

    assign pc        = r_pc;
    assign pcp4      = r_pc + c_pc_inc;
    assign ras_count = w_ras_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_jump_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_jump_unit
//  Description : Self-checking bench for pc_jump_unit: directed vector table,
//                mid-cycle reset sequence and randomized run against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_jump_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect, jump_valid, jump_link, jr_valid, jr_is_ra;
    logic [31:0] redirect_pc, jr_target, pcp4_id;
    logic [25:0] jump_imm;
    logic [31:0] pc, pcp4;
    logic        ras_used;
    logic [2:0]  ras_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pc_jump_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .jump_valid  (jump_valid),
        .jump_link   (jump_link),
        .jump_imm    (jump_imm),
        .jr_valid    (jr_valid),
        .jr_is_ra    (jr_is_ra),
        .jr_target   (jr_target),
        .pcp4_id     (pcp4_id),
        .pc          (pc),
        .pcp4        (pcp4),
        .ras_used    (ras_used),
        .ras_count   (ras_count)
    );

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        jv;
        logic        jl;
        logic [25:0] imm;
        logic        jrv;
        logic        jra;
        logic [31:0] jrt;
        logic [31:0] pid;
        logic [31:0] exp_pc;
        int          exp_cnt;
        logic        exp_used;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic s, input logic rd, input logic [31:0] rpc,
                                input logic jv, input logic jl, input logic [25:0] imm,
                                input logic jrv, input logic jra, input logic [31:0] jrt,
                                input logic [31:0] pid, input logic [31:0] epc,
                                input int ecnt, input logic eused);
        vec_t v;
        v.stall = s;   v.redir = rd; v.rpc = rpc; v.jv = jv; v.jl = jl; v.imm = imm;
        v.jrv = jrv;   v.jra = jra;  v.jrt = jrt; v.pid = pid;
        v.exp_pc = epc; v.exp_cnt = ecnt; v.exp_used = eused;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        stall = v.stall; redirect = v.redir; redirect_pc = v.rpc;
        jump_valid = v.jv; jump_link = v.jl; jump_imm = v.imm;
        jr_valid = v.jrv; jr_is_ra = v.jra; jr_target = v.jrt; pcp4_id = v.pid;
    endtask

    task automatic idle();
        stall = 0; redirect = 0; redirect_pc = '0; jump_valid = 0; jump_link = 0;
        jump_imm = '0; jr_valid = 0; jr_is_ra = 0; jr_target = '0; pcp4_id = '0;
    endtask

    // Reference model state: architectural PC and a bounded LIFO of return addresses
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];

    initial begin
        logic [31:0] hi_mask;
        logic        e_used;
        vec_t        v;
        hi_mask = 32'hF000_0000;

        // ---------------- directed table ----------------
        vt.push_back(mk(0,0,0,          0,0,26'h0,    0,0,0,             0,            32'h0000_0004,0,0));
        vt.push_back(mk(0,0,0,          0,0,26'h0,    0,0,0,             0,            32'h0000_0008,0,0));
        vt.push_back(mk(0,0,0,          1,0,26'h100,  0,0,0,             32'h4000_0010,32'h4000_0400,0,0));
        vt.push_back(mk(0,0,0,          1,1,26'h40,   0,0,0,             32'h0000_0020,32'h0000_0100,1,0));
        vt.push_back(mk(0,0,0,          0,0,26'h0,    1,1,32'hDEAD_0000, 0,            32'h0000_0020,0,1));
        for (int i = 1; i <= 5; i++)
            vt.push_back(mk(0,0,0,      1,1,26'h10,   0,0,0,             32'(i*32'h1000),32'h0000_0040,(i>4)?4:i,0));
        for (int i = 5; i >= 2; i--)
            vt.push_back(mk(0,0,0,      0,0,26'h0,    1,1,32'hDEAD_0000, 0,            32'(i*32'h1000),i-2,1));
        vt.push_back(mk(0,0,0,          0,0,26'h0,    1,1,32'h0000_0888, 0,            32'h0000_0888,0,0));
        vt.push_back(mk(0,0,0,          1,1,26'h20,   0,0,0,             32'h0000_0600,32'h0000_0080,1,0));
        vt.push_back(mk(1,0,0,          1,1,26'h30,   0,0,0,             32'h0000_0700,32'h0000_0080,1,0));
        vt.push_back(mk(1,0,0,          0,0,26'h0,    1,1,32'h0000_0444, 0,            32'h0000_0080,1,0));
        vt.push_back(mk(1,1,32'h0000_0C00,0,0,26'h0,  1,1,32'h0000_0444, 0,            32'h0000_0C00,1,0));
        vt.push_back(mk(1,1,32'h0000_0080,0,0,26'h0,  0,0,0,             0,            32'h0000_0080,1,0));
        vt.push_back(mk(0,0,0,          1,1,26'h55,   1,0,32'h0000_1234, 32'h0000_0990,32'h0000_1234,1,0));
        vt.push_back(mk(0,1,32'hFFFF_FFFC,0,0,26'h0,  0,0,0,             0,            32'hFFFF_FFFC,1,0));
        vt.push_back(mk(0,0,0,          0,0,26'h0,    0,0,0,             0,            32'h0000_0000,1,0));

        // ---------------- reset ----------------
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_pc",    pc,              32'h0);
        chk("reset_pcp4",  pcp4,            32'h4);
        chk("reset_count", 32'(ras_count),  32'h0);
        chk("reset_used",  32'(ras_used),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[k]) begin
            drive(vt[k]);
            #1;
            chk($sformatf("v%0d_used", k), 32'(ras_used), 32'(vt[k].exp_used));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", k),    pc,             vt[k].exp_pc);
            chk($sformatf("v%0d_pcp4", k),  pcp4,           vt[k].exp_pc + 32'd4);
            chk($sformatf("v%0d_count", k), 32'(ras_count), 32'(vt[k].exp_cnt));
            @(negedge clk);
        end

        // ---------------- mid-cycle asynchronous reset ----------------
        // pc=0, count=1 entering here
        drive(mk(0,0,0, 1,1,26'h50, 0,0,0, 32'h0000_0900, 0,0,0));
        @(posedge clk); #1;
        chk("pre_rst_pc",    pc,             32'h0000_0140);
        chk("pre_rst_count", 32'(ras_count), 32'h2);
        @(negedge clk);
        drive(mk(0,0,0, 0,0,26'h0, 1,1,32'h0000_0AAA, 0, 0,0,0));
        #1;
        chk("pre_rst_used",  32'(ras_used),  32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc",    pc,             32'h0);
        chk("async_rst_count", 32'(ras_count), 32'h0);
        chk("async_rst_used",  32'(ras_used),  32'h0);
        @(posedge clk); #1;
        chk("held_rst_pc",     pc,             32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        // ---------------- randomized run vs reference model ----------------
        m_pc = 32'h0;
        m_ras.delete();
        for (int n = 0; n < 400; n++) begin
            int op;
            v.redir = ($urandom_range(0, 99) < 8);
            v.stall = ($urandom_range(0, 7) == 0);
            v.rpc   = $urandom;
            op      = $urandom_range(0, 9);
            v.jv    = (op >= 3 && op <= 6) || (op == 9);
            v.jrv   = (op >= 7);
            v.jl    = $urandom_range(0, 2) != 0;
            v.jra   = $urandom_range(0, 3) != 0;
            v.imm   = 26'($urandom);
            v.jrt   = $urandom;
            v.pid   = $urandom & 32'hFFFF_FFFC;
            drive(v);

            e_used = !v.redir && !v.stall && v.jrv && v.jra && (m_ras.size() > 0);
            #1;
            chk($sformatf("r%0d_used", n), 32'(ras_used), 32'(e_used));

            if (v.redir) begin
                m_pc = v.rpc;
            end else if (v.stall) begin
                m_pc = m_pc;
            end else if (v.jrv) begin
                if (v.jra && m_ras.size() > 0) m_pc = m_ras.pop_back();
                else                           m_pc = v.jrt;
            end else if (v.jv) begin
                m_pc = (v.pid & hi_mask) + (32'(v.imm) * 4);
                if (v.jl) begin
                    m_ras.push_back(v.pid);
                    if (m_ras.size() > 4) void'(m_ras.pop_front());
                end
            end else begin
                m_pc = m_pc + 32'd4;
            end

            @(posedge clk); #1;
            chk($sformatf("r%0d_pc", n),    pc,             m_pc);
            chk($sformatf("r%0d_pcp4", n),  pcp4,           m_pc + 32'd4);
            chk($sformatf("r%0d_count", n), 32'(ras_count), 32'(m_ras.size()));
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
